tf530_bus_top: RTL and testbench

Bus bridge between the accelerator CPU (68030-style asynchronous bus: AS20/DS20/RW20/SIZ/FC) and the host 68000 motherboard bus (AS/UDS/LDS/RW, DTACK, VPA/VMA/E).

- Runs each external CPU cycle as a 68000 bus cycle aligned to the 7 MHz host clock.
- Terminates cycles on a 16-bit port (DSACK1 only).
- Handles CPU-space cycles: autovector interrupt acknowledge, and bus error on absent-coprocessor access.
- Cycles claimed by the on-card RAM/IDE block are left alone.

---
 rtl/tf530_bus_top.sv | 224 ++++++++++++++++++++++
 tb/tb_tf530_bus_top.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tf530_bus_top.sv
// tf530_bus_top: bridges the 68030-style accelerator bus onto the 7 MHz
// 68000 host bus. Host cycles are paced by a synchronised copy of CLK7M,
// terminated to the CPU as a 16-bit port (DSACK1), with CPU-space cycles
// answered locally by autovector or bus error.
module tf530_bus_top (
  input  logic        CLKCPU,
  input  logic        RESET,
  input  logic        CLK7M,
  input  logic        INTCYCLE,
  input  logic        IDEWAIT,
  input  logic        CPSENSE,
  input  logic        BG20,
  input  logic        AS20,
  input  logic        DS20,
  input  logic        RW20,
  input  logic [2:0]  FC,
  input  logic [1:0]  SIZ,
  input  logic [23:0] A,
  input  logic        BGACK,
  input  logic        VPA,
  input  logic        DTACK,
  input  logic [2:0]  IPL,
  output logic        BG,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  output logic        VMA,
  output logic        E,
  output logic        BERR,
  output logic [1:0]  DSACK,
  output logic        AVEC
);

  typedef enum logic [2:0] {
    S_IDLE,     // waiting for AS20
    S_START,    // host AS asserted, waiting for 7M falling edge
    S_WAIT,     // sampling DTACK / VPA on 7M falling edges
    S_VPAWAIT,  // 6800-style cycle synchronised to E
    S_ACK,      // terminating to the CPU via DSACK1
    S_HOLD,     // local or internal cycle, waiting for AS20 to negate
    S_RECOVER   // host AS held high for a full 7M period
  } state_t;

  // Internal control flags; strobes are stored as "asserted" (active high)
  // and inverted onto the pins. rw holds the host RW level directly.
  typedef struct packed {
    logic as;
    logic uds;
    logic lds;
    logic rw;
    logic vma;
    logic dsack;
    logic avec;
    logic berr;
    logic rec_half;
  } ctl_t;

  localparam ctl_t CTL_RESET = '{as: 1'b0, uds: 1'b0, lds: 1'b0, rw: 1'b1,
                                 vma: 1'b0, dsack: 1'b0, avec: 1'b0,
                                 berr: 1'b0, rec_half: 1'b0};

  state_t     state, state_n;
  ctl_t       ctl, ctl_n;
  logic [2:0] c7_sync;
  logic [3:0] e_cnt;
  logic       rise7, fall7;
  logic       iack_cyc, cop_cyc;
  logic       uds_en, lds_en;
  logic       unused_inputs;

  // DS20 timing, the interrupt level and the undecoded address bits are not
  // needed by the bridge itself.
  assign unused_inputs = ^{DS20, IPL, A[23:20], A[15:1]};

  // Two-flop synchroniser for CLK7M plus one more stage for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse stages.
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) c7_sync <= 3'b000;
    else        c7_sync <= {c7_sync[1:0], CLK7M};
  end

  assign rise7 =  c7_sync[1] & ~c7_sync[2];
  assign fall7 = ~c7_sync[1] &  c7_sync[2];

  // E clock divider: modulo-10 count of synchronised CLK7M rising edges.
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET)     e_cnt <= 4'd0;
    else if (rise7) e_cnt <= (e_cnt == 4'd9) ? 4'd0 : e_cnt + 4'd1;
  end

  assign E = (e_cnt >= 4'd6);

  // CPU-space decode and data-strobe selection for the current cycle.
  assign iack_cyc = (FC == 3'b111) && (A[19:16] == 4'hF);
  assign cop_cyc  = (FC == 3'b111) && (A[19:16] == 4'h2) && CPSENSE;
  assign uds_en   = ~A[0];
  assign lds_en   = A[0] | (SIZ != 2'b01);

  // State and control register.
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
      ctl   <= CTL_RESET;
    end else begin
      state <= state_n;
      ctl   <= ctl_n;
    end
  end

  // Next-state and next-control decode for the bus cycle sequencer.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit; a missing branch
    // would otherwise infer a latch instead of holding the registered value.
    state_n = state;
    ctl_n   = ctl;

    case (state)
      S_IDLE: begin
        if (!AS20) begin
          if (iack_cyc) begin
            ctl_n.avec = 1'b1;
            state_n    = S_HOLD;
          end else if (cop_cyc) begin
            ctl_n.berr = 1'b1;
            state_n    = S_HOLD;
          end else if (INTCYCLE) begin
            state_n = S_HOLD;
          end else if (IDEWAIT && BGACK && rise7) begin
            ctl_n.as = 1'b1;
            ctl_n.rw = RW20;
            if (RW20) begin
              ctl_n.uds = uds_en;
              ctl_n.lds = lds_en;
            end
            state_n = S_START;
          end
        end
      end

      S_START: begin
        if (AS20) begin
          ctl_n   = CTL_RESET;
          state_n = S_RECOVER;
        end else if (fall7) begin
          // Write data is valid by now, so write strobes follow AS by half a 7M period.
          if (!ctl.rw) begin
            ctl_n.uds = uds_en;
            ctl_n.lds = lds_en;
          end
          state_n = S_WAIT;
        end
      end

      S_WAIT: begin
        if (AS20) begin
          ctl_n   = CTL_RESET;
          state_n = S_RECOVER;
        end else if (fall7) begin
          if (!DTACK)    state_n = S_ACK;
          else if (!VPA) state_n = S_VPAWAIT;
        end
      end

      S_VPAWAIT: begin
        if (AS20) begin
          ctl_n   = CTL_RESET;
          state_n = S_RECOVER;
        end else if (rise7) begin
          // VMA goes low as E reaches count 3; the cycle ends as E falls (9 -> 0).
          if (!ctl.vma && e_cnt == 4'd2)     ctl_n.vma = 1'b1;
          else if (ctl.vma && e_cnt == 4'd9) state_n   = S_ACK;
        end
      end

      S_ACK: begin
        if (AS20) begin
          ctl_n   = CTL_RESET;
          state_n = S_RECOVER;
        end else begin
          ctl_n.dsack = 1'b1;
        end
      end

      S_HOLD: begin
        if (AS20) begin
          ctl_n   = CTL_RESET;
          state_n = S_IDLE;
        end
      end

      S_RECOVER: begin
        // Two 7M rising edges guarantee a full period with host AS negated.
        if (rise7) begin
          if (ctl.rec_half) begin
            ctl_n.rec_half = 1'b0;
            state_n        = S_IDLE;
          end else begin
            ctl_n.rec_half = 1'b1;
          end
        end
      end

      default: begin
        ctl_n   = CTL_RESET;
        state_n = S_IDLE;
      end
    endcase
  end

  // Pin drivers: host strobes float while an alternate master owns the bus;
  // BERR and DSACK are open-drain.
  assign BG    = BG20;
  assign AS    = BGACK ? ~ctl.as  : 1'bz;
  assign UDS   = BGACK ? ~ctl.uds : 1'bz;
  assign LDS   = BGACK ? ~ctl.lds : 1'bz;
  assign RW    = BGACK ?  ctl.rw  : 1'bz;
  assign VMA   = ~ctl.vma;
  assign AVEC  = ~ctl.avec;
  assign BERR  = ctl.berr  ? 1'b0 : 1'bz;
  assign DSACK = {ctl.dsack ? 1'b0 : 1'bz, 1'bz};

endmodule

// File: tb/tb_tf530_bus_top.sv
// Testbench for tf530_bus_top: directed CPU cycles with a scoreboard queue of
// expected terminations, checked by an independent monitor process.
module tb_tf530_bus_top;

  logic        CLKCPU = 1'b0;
  logic        RESET = 1'b0;
  logic        CLK7M = 1'b0;
  logic        INTCYCLE = 1'b0;
  logic        IDEWAIT = 1'b1;
  logic        CPSENSE = 1'b0;
  logic        BG20 = 1'b1;
  logic        AS20 = 1'b1;
  logic        DS20 = 1'b1;
  logic        RW20 = 1'b1;
  logic [2:0]  FC = 3'b101;
  logic [1:0]  SIZ = 2'b10;
  logic [23:0] A = 24'h0;
  logic        BGACK = 1'b1;
  logic        VPA = 1'b1;
  logic        DTACK = 1'b1;
  logic [2:0]  IPL = 3'b111;

  wire         bg_w, as_w, uds_w, lds_w, rw_w, vma_w, e_w, avec_w;
  tri1         berr_w;
  tri1 [1:0]   dsack_w;

  tf530_bus_top dut (
    .CLKCPU(CLKCPU), .RESET(RESET), .CLK7M(CLK7M), .INTCYCLE(INTCYCLE),
    .IDEWAIT(IDEWAIT), .CPSENSE(CPSENSE), .BG20(BG20), .AS20(AS20),
    .DS20(DS20), .RW20(RW20), .FC(FC), .SIZ(SIZ), .A(A), .BGACK(BGACK),
    .VPA(VPA), .DTACK(DTACK), .IPL(IPL), .BG(bg_w), .AS(as_w), .UDS(uds_w),
    .LDS(lds_w), .RW(rw_w), .VMA(vma_w), .E(e_w), .BERR(berr_w),
    .DSACK(dsack_w), .AVEC(avec_w)
  );

  always #5 CLKCPU = ~CLKCPU;
  initial begin
    #2;
    forever #40 CLK7M = ~CLK7M;
  end

  int n_tests = 0;
  int n_failed = 0;

  // Expected termination: kind (1 DSACK, 2 AVEC, 3 BERR) and host pins
  // {AS, UDS, LDS, RW, VMA} at the moment it appears.
  typedef struct {
    string      name;
    logic [6:0] resp;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_term(input string name, input logic [1:0] kind,
                             input logic [4:0] pins);
    exp_t e;
    e.name = name;
    e.resp = {kind, pins};
    exp_q.push_back(e);
  endtask

  // Monitor: a falling DSACK1/AVEC/BERR is a termination; compare with the queue.
  initial begin
    logic       p_ds = 1'b1, p_av = 1'b1, p_be = 1'b1;
    logic [1:0] kind;
    exp_t       e;
    forever begin
      @(negedge CLKCPU);
      kind = 2'd0;
      if (RESET) begin
        if (p_ds && !dsack_w[1])   kind = 2'd1;
        else if (p_av && !avec_w)  kind = 2'd2;
        else if (p_be && !berr_w)  kind = 2'd3;
      end
      if (kind != 2'd0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_term", {30'd0, kind}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check(e.name, {25'd0, kind, as_w, uds_w, lds_w, rw_w, vma_w},
                {25'd0, e.resp});
        end
      end
      p_ds = dsack_w[1];
      p_av = avec_w;
      p_be = berr_w;
    end
  end

  task automatic start_cycle(input logic [2:0] fc, input logic [23:0] a,
                             input logic [1:0] siz, input logic rw);
    @(negedge CLKCPU);
    FC = fc; A = a; SIZ = siz; RW20 = rw;
    AS20 = 1'b0; DS20 = 1'b0;
  endtask

  task automatic wait_term(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge CLKCPU);
      if (!dsack_w[1] || !avec_w || !berr_w) ok = 1'b1;
    end
    check({name, "_term_seen"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_as_low(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge CLKCPU);
      if (!as_w) ok = 1'b1;
    end
    check({name, "_as_seen"}, {31'd0, ok}, 32'd1);
  endtask

  // Termination is held until AS20 rises, then everything releases one cycle later.
  task automatic end_cycle(input string name, input logic [2:0] held);
    @(negedge CLKCPU);
    check({name, "_held"}, {29'd0, dsack_w[1], avec_w, berr_w}, {29'd0, held});
    AS20 = 1'b1; DS20 = 1'b1;
    @(negedge CLKCPU);
    check({name, "_release"},
          {22'd0, dsack_w, avec_w, berr_w, as_w, uds_w, lds_w, vma_w},
          {22'd0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
  endtask

  initial begin
    bit seen;

    repeat (3) @(negedge CLKCPU);
    check("reset_pins",
          {22'd0, as_w, uds_w, lds_w, rw_w, vma_w, e_w, dsack_w, berr_w, avec_w},
          {22'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1});
    RESET = 1'b1;
    repeat (4) @(negedge CLKCPU);

    // Word read, DTACK already low: acked on the second 7M falling edge.
    DTACK = 1'b0;
    expect_term("word_read", 2'd1, 5'b00011);
    start_cycle(3'b101, 24'hF80000, 2'b10, 1'b1);
    wait_term("word_read");
    end_cycle("word_read", 3'b011);
    DTACK = 1'b1;

    // Byte write at odd address: LDS only, and only after AS.
    DTACK = 1'b0;
    expect_term("byte_write", 2'd1, 5'b01001);
    start_cycle(3'b101, 24'hDFF031, 2'b01, 1'b0);
    wait_as_low("byte_write");
    check("byte_write_ds_late", {30'd0, uds_w, lds_w}, 32'd3);
    wait_term("byte_write");
    end_cycle("byte_write", 3'b011);
    DTACK = 1'b1;

    // VPA cycle: VMA low while E is low (count 3), ack only after E falls.
    VPA = 1'b0;
    expect_term("vpa_read", 2'd1, 5'b01010);
    start_cycle(3'b101, 24'hBFE001, 2'b01, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge CLKCPU);
      if (!vma_w) seen = 1'b1;
    end
    check("vpa_vma_seen", {31'd0, seen}, 32'd1);
    check("vpa_vma_state", {30'd0, e_w, dsack_w[1]}, {30'd0, 1'b0, 1'b1});
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge CLKCPU);
      if (e_w) seen = 1'b1;
    end
    check("vpa_e_high_before_ack", {30'd0, seen, dsack_w[1]}, {30'd0, 1'b1, 1'b1});
    wait_term("vpa_read");
    check("vpa_e_low_at_ack", {31'd0, e_w}, 32'd0);
    end_cycle("vpa_read", 3'b011);
    VPA = 1'b1;

    // Interrupt acknowledge: autovector, host AS untouched.
    expect_term("iack", 2'd2, 5'b11111);
    start_cycle(3'b111, 24'h0FFFF7, 2'b01, 1'b1);
    wait_term("iack");
    end_cycle("iack", 3'b101);

    // Absent coprocessor: bus error, no host cycle.
    CPSENSE = 1'b1;
    expect_term("cop_berr", 2'd3, 5'b11111);
    start_cycle(3'b111, 24'h022000, 2'b00, 1'b1);
    wait_term("cop_berr");
    end_cycle("cop_berr", 3'b110);
    CPSENSE = 1'b0;

    // Internal cycle: nothing on the host bus, no DSACK from the bridge.
    INTCYCLE = 1'b1; DTACK = 1'b0;
    start_cycle(3'b101, 24'h200000, 2'b00, 1'b1);
    seen = 1'b0;
    repeat (60) begin
      @(negedge CLKCPU);
      if (!as_w || !uds_w || !lds_w || !dsack_w[1]) seen = 1'b1;
    end
    check("intcycle_quiet", {31'd0, seen}, 32'd0);
    AS20 = 1'b1; DS20 = 1'b1;
    @(negedge CLKCPU);
    INTCYCLE = 1'b0; DTACK = 1'b1;

    // Aborted cycle: AS20 negates before any acknowledge.
    start_cycle(3'b101, 24'h000100, 2'b10, 1'b1);
    wait_as_low("abort");
    @(negedge CLKCPU);
    AS20 = 1'b1; DS20 = 1'b1;
    @(negedge CLKCPU);
    check("abort_strobes", {29'd0, as_w, uds_w, lds_w}, 32'd7);

    // Reset in the middle of a host cycle.
    start_cycle(3'b101, 24'h000200, 2'b10, 1'b1);
    wait_as_low("midreset");
    RESET = 1'b0;
    #1;
    check("midreset_pins",
          {25'd0, as_w, uds_w, lds_w, rw_w, vma_w, dsack_w[1], e_w},
          {25'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    @(negedge CLKCPU);
    AS20 = 1'b1; DS20 = 1'b1;
    @(negedge CLKCPU);
    RESET = 1'b1;
    repeat (4) @(negedge CLKCPU);

    // Alternate bus master: no cycle may start even with DTACK low.
    BGACK = 1'b0; DTACK = 1'b0;
    start_cycle(3'b101, 24'h000300, 2'b10, 1'b1);
    seen = 1'b0;
    repeat (60) begin
      @(negedge CLKCPU);
      if (!dsack_w[1]) seen = 1'b1;
    end
    check("bgack_no_cycle", {31'd0, seen}, 32'd0);
    AS20 = 1'b1; DS20 = 1'b1;
    @(negedge CLKCPU);
    BGACK = 1'b1; DTACK = 1'b1;
    repeat (2) @(negedge CLKCPU);
    check("bgack_as_idle", {31'd0, as_w}, 32'd1);

    repeat (20) @(negedge CLKCPU);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
